gtx_drp_arb: RTL and testbench
==============================

Name: gtx_drp_arb

Overview:
- Shares the single GTX quad DRP port between two requesters: the channel-0 and channel-1 tuning/config logic.
- Accepts one read or write per grant and drives the 7-series DRP handshake (en/we/addr/di -> rdy/do).
- Returns read data or a timeout error to the winning requester.
- Sits beside the dual-channel GTX wrapper on the DRP clock. All DRP access from the SATA PHY goes through this block.

Parameters:
- C_ADDR_W, 9, DRP address width.
- C_TIMEOUT, 63, max cycles spent in WAIT before the access is aborted with error. Legal range 2..255.

Ports:
- sys_clk  in  1  DRP clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an access pending; held until accepted.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  C_ADDR_W  DRP address.
- req0_wdata  in  16  write data.
- req0_ready  out  1  accept strobe; the transfer occurs on valid&ready.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  16  read data, valid while done=1.
- req0_err  out  1  timeout flag, valid while done=1.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata, req1_err: same as requester 0.
- drp_en  out  1  DRP enable, single-cycle pulse.
- drp_we  out  1  DRP write enable, qualified by drp_en.
- drp_addr  out  C_ADDR_W  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid with drp_rdy.
- drp_rdy  in  1  DRP completion.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE, last_grant=1 (so req0 wins the first tie). All outputs 0, including busy, drp_addr, drp_di, rdata and err.
- Reset is asynchronous and may occur mid-access. The block returns to IDLE immediately, issues no done pulse and no further drp_en. A drp_rdy arriving after reset is ignored.
- State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - req*_ready is combinational: asserted for the granted requester only, and only in IDLE.
  - With only one requester valid, that requester is granted.
  - With both valid, round-robin grants the requester that is not last_grant.
  - On accept, latch we/addr/wdata and the grant index; next state ISSUE.
- ISSUE (one cycle):
  - drp_en=1; drp_we/drp_addr/drp_di driven from the latched values.
  - drp_addr/drp_di hold their values until the next ISSUE.
  - drp_en is never high outside ISSUE.
  - Clear the timeout counter; next state WAIT.
- WAIT:
  - The counter increments each cycle.
  - If drp_rdy=1: capture drp_do (reads only; writes capture 0) and set err=0.
  - Else if counter==C_TIMEOUT-1: set err=1 and rdata=0.
  - drp_rdy on the terminal timeout cycle wins, so err=0.
  - Either exit goes to DONE.
- DONE (one cycle):
  - reqN_done=1 with rdata/err for the latched grant index; the other requester's done stays 0.
  - last_grant <= grant index; next state IDLE.
- drp_rdy in IDLE, ISSUE or DONE is ignored and produces no side effects.
- Minimum latency: accept at cycle t, drp_en at t+1, drp_rdy earliest at t+2, done at t+3. The next accept is possible at t+4.
- A requester may deassert valid only after being accepted. Requester behaviour that breaks this rule is undefined and is not checked.
- rdata/err hold their values after done until the next DONE.

Test Plan:
- Single read: req0 read addr 0x05F, DRP returns 0xA5C3 two cycles after en -> one drp_en with we=0, addr=0x05F; req0_done for one cycle with rdata=0xA5C3, err=0; req1_done stays 0.
- Write: req1 write addr 0x088, data 0x1234 -> drp_en with we=1, addr=0x088, di=0x1234; req1_done with err=0, rdata=0x0000.
- Contention: both valid from reset, each issuing 3 back-to-back accesses -> grant order 0,1,0,1,0,1. Exactly one drp_en per access; accepts are spaced at least 4 cycles apart.
- Timeout: drp_rdy never asserted, C_TIMEOUT=63 -> done with err=1, rdata=0 at the 63rd WAIT cycle. Variant with drp_rdy on that same cycle -> err=0, rdata=drp_do.
- Spurious and late rdy: drp_rdy pulsed in IDLE and in DONE -> no done, no state change.
- Async reset asserted in WAIT -> all outputs 0 in the same cycle; no done pulse after release; the next contended grant goes to req0.

Source files
------------

// File: rtl/gtx_drp_arb.sv
// -----------------------------------------------------------------------------
// gtx_drp_arb
//
// Shares the single GTX quad DRP port between two requesters (channel-0 and
// channel-1 tuning/config logic). Each grant carries exactly one read or write
// through the 7-series DRP handshake and returns read data, or a timeout
// error, to the requester that won the grant.
//
// Sequence per access:  IDLE -> ISSUE -> WAIT -> DONE -> IDLE
//
// Ports
//   sys_clk, sys_rst          DRP clock; asynchronous active-high reset
//   reqN_valid/we/addr/wdata  access request from requester N (held until ready)
//   reqN_ready                accept strobe, combinational, IDLE only
//   reqN_done                 one-cycle completion pulse
//   reqN_rdata/reqN_err       read data / timeout flag, valid while done=1
//   drp_en/we/addr/di         DRP request side (drp_en is a one-cycle pulse)
//   drp_do/drp_rdy            DRP response side
//   busy                      high whenever an access is in flight
// -----------------------------------------------------------------------------
module gtx_drp_arb #(
  parameter int C_ADDR_W  = 9,
  parameter int C_TIMEOUT = 63
) (
  input  logic                sys_clk,
  input  logic                sys_rst,

  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [C_ADDR_W-1:0] req0_addr,
  input  logic [15:0]         req0_wdata,
  output logic                req0_ready,
  output logic                req0_done,
  output logic [15:0]         req0_rdata,
  output logic                req0_err,

  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [C_ADDR_W-1:0] req1_addr,
  input  logic [15:0]         req1_wdata,
  output logic                req1_ready,
  output logic                req1_done,
  output logic [15:0]         req1_rdata,
  output logic                req1_err,

  output logic                drp_en,
  output logic                drp_we,
  output logic [C_ADDR_W-1:0] drp_addr,
  output logic [15:0]         drp_di,
  input  logic [15:0]         drp_do,
  input  logic                drp_rdy,

  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter value on the last permitted WAIT cycle.
  localparam logic [7:0] C_TERM = 8'(C_TIMEOUT - 1);

  state_t      state;
  logic        last_grant;  // requester served by the most recent access
  logic        grant;       // requester owning the access in flight
  logic [7:0]  wait_cnt;

  logic        gnt1;
  logic        accept;
  logic        wait_exit;
  logic [15:0] rdata_nxt;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not served last wins.
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);

  // NOTE: ready is gated by sys_rst so that every output reads 0 while the
  // block is held in reset, even if a requester keeps valid high.
  assign req1_ready = ~sys_rst & (state == S_IDLE) & gnt1;
  assign req0_ready = ~sys_rst & (state == S_IDLE) & req0_valid & ~gnt1;
  assign accept     = req0_ready | req1_ready;

  // drp_rdy on the terminal cycle takes precedence over the timeout.
  assign wait_exit  = drp_rdy | (wait_cnt == C_TERM);
  // Writes and timeouts both return zero data.
  assign rdata_nxt  = (drp_rdy && !drp_we) ? drp_do : 16'h0000;

  // NOTE: every register here, including the DRP outputs and returned data,
  // is cleared by the asynchronous reset so an aborted access leaves nothing
  // behind, and all state updates use non-blocking assignments so each
  // branch sees the values from the start of the cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wait_cnt   <= 8'd0;
      drp_en     <= 1'b0;
      drp_we     <= 1'b0;
      drp_addr   <= '0;
      drp_di     <= 16'h0000;
      busy       <= 1'b0;
      req0_done  <= 1'b0;
      req0_rdata <= 16'h0000;
      req0_err   <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= 16'h0000;
      req1_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // The DRP request registers double as the latch for the access;
            // they hold until the next accept.
            grant    <= req1_ready;
            drp_we   <= req1_ready ? req1_we    : req0_we;
            drp_addr <= req1_ready ? req1_addr  : req0_addr;
            drp_di   <= req1_ready ? req1_wdata : req0_wdata;
            drp_en   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          drp_en   <= 1'b0;
          wait_cnt <= 8'd0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (wait_exit) begin
            state <= S_DONE;
            if (grant) begin
              req1_done  <= 1'b1;
              req1_rdata <= rdata_nxt;
              req1_err   <= ~drp_rdy;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= rdata_nxt;
              req0_err   <= ~drp_rdy;
            end
          end
        end

        S_DONE: begin
          req0_done  <= 1'b0;
          req1_done  <= 1'b0;
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gtx_drp_arb.sv
// -----------------------------------------------------------------------------
// tb_gtx_drp_arb
//
// Self-checking bench for gtx_drp_arb. Single-requester accesses come from a
// table of hand-computed vectors; contention, spurious drp_rdy and reset in
// WAIT are written out as explicit sequences. Inputs change 1 ns after the
// rising edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_gtx_drp_arb;

  localparam int C_ADDR_W  = 9;
  localparam int C_TIMEOUT = 63;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                req0_valid, req0_we, req0_ready, req0_done, req0_err;
  logic [C_ADDR_W-1:0] req0_addr;
  logic [15:0]         req0_wdata, req0_rdata;
  logic                req1_valid, req1_we, req1_ready, req1_done, req1_err;
  logic [C_ADDR_W-1:0] req1_addr;
  logic [15:0]         req1_wdata, req1_rdata;
  logic                drp_en, drp_we, drp_rdy, busy;
  logic [C_ADDR_W-1:0] drp_addr;
  logic [15:0]         drp_di, drp_do;

  int n_checks = 0;
  int n_errors = 0;

  gtx_drp_arb #(.C_ADDR_W(C_ADDR_W), .C_TIMEOUT(C_TIMEOUT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req0_err   (req0_err),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .req1_err   (req1_err),
    .drp_en     (drp_en),
    .drp_we     (drp_we),
    .drp_addr   (drp_addr),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_rdy    (drp_rdy),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic                req;          // requester index
    logic                we;
    logic [C_ADDR_W-1:0] addr;
    logic [15:0]         wdata;
    int                  rdy_at;       // WAIT cycle index of drp_rdy, -1 = never
    logic [15:0]         do_val;
    logic                rdy_in_done;  // pulse a stray drp_rdy during DONE
    logic [15:0]         exp_rdata;
    logic                exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drp_en"},   32'(drp_en),   0);
    check({tag, "_drp_we"},   32'(drp_we),   0);
    check({tag, "_drp_addr"}, 32'(drp_addr), 0);
    check({tag, "_drp_di"},   32'(drp_di),   0);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_ready"},    32'({req0_ready, req1_ready}), 0);
    check({tag, "_done"},     32'({req0_done, req1_done}),   0);
    check({tag, "_rdata0"},   32'(req0_rdata), 0);
    check({tag, "_rdata1"},   32'(req1_rdata), 0);
    check({tag, "_err"},      32'({req0_err, req1_err}),     0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    tick();
  endtask

  // One complete access from a single requester, checked cycle by cycle.
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    int    k;
    int    en_cnt;
    int    exp_iter;
    bit    seen;
    p = $sformatf("v%0d", idx);
    if (v.req) begin
      req1_valid = 1'b1; req1_we = v.we; req1_addr = v.addr; req1_wdata = v.wdata;
    end else begin
      req0_valid = 1'b1; req0_we = v.we; req0_addr = v.addr; req0_wdata = v.wdata;
    end
    drp_do = v.do_val;
    #1;
    check({p, "_ready"},       32'(v.req ? req1_ready : req0_ready), 1);
    check({p, "_ready_other"}, 32'(v.req ? req0_ready : req1_ready), 0);
    tick();  // ISSUE
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({p, "_drp_en"},   32'(drp_en),   1);
    check({p, "_drp_we"},   32'(drp_we),   32'(v.we));
    check({p, "_drp_addr"}, 32'(drp_addr), 32'(v.addr));
    check({p, "_drp_di"},   32'(drp_di),   32'(v.wdata));
    check({p, "_busy"},     32'(busy),     1);
    tick();  // first WAIT cycle
    en_cnt = 0;
    seen   = 0;
    for (k = 0; k < 300; k++) begin
      if (drp_en) en_cnt++;
      drp_rdy = (k == v.rdy_at);
      tick();
      drp_rdy = 1'b0;
      if (req0_done || req1_done) begin
        seen = 1;
        break;
      end
    end
    exp_iter = (v.rdy_at < 0) ? C_TIMEOUT : v.rdy_at + 1;
    check({p, "_done_seen"},   32'(seen),   1);
    check({p, "_wait_cycles"}, 32'(k + 1),  32'(exp_iter));
    check({p, "_extra_en"},    32'(en_cnt), 0);
    check({p, "_done"},        32'(v.req ? req1_done : req0_done), 1);
    check({p, "_done_other"},  32'(v.req ? req0_done : req1_done), 0);
    check({p, "_rdata"},       32'(v.req ? req1_rdata : req0_rdata), 32'(v.exp_rdata));
    check({p, "_err"},         32'(v.req ? req1_err : req0_err),     32'(v.exp_err));
    drp_rdy = v.rdy_in_done;
    drp_do  = 16'hFFFF;
    tick();  // back in IDLE
    drp_rdy = 1'b0;
    check({p, "_done_clr"},   32'({req0_done, req1_done}), 0);
    check({p, "_idle_busy"},  32'(busy), 0);
    check({p, "_rdata_hold"}, 32'(v.req ? req1_rdata : req0_rdata), 32'(v.exp_rdata));
    check({p, "_err_hold"},   32'(v.req ? req1_err : req0_err),     32'(v.exp_err));
    tick();
    check({p, "_quiet_done"}, 32'({req0_done, req1_done}), 0);
    check({p, "_quiet_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic exp_order[6];
    int   rem0, rem1, ng, en_cnt, d0, d1, last_acc, min_gap, gap;
    bit   en_prev;
    logic g;

    vecs[0] = '{1'b0, 1'b0, 9'h05F, 16'h0000,  1, 16'hA5C3, 1'b0, 16'hA5C3, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 9'h088, 16'h1234,  0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 9'h0C0, 16'h0000, -1, 16'h5555, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 9'h101, 16'h0000, 62, 16'h7E81, 1'b0, 16'h7E81, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 9'h0F0, 16'h0000, 61, 16'h0F0F, 1'b0, 16'h0F0F, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 9'h1FF, 16'hFFFF,  3, 16'h9999, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 9'h000, 16'h0000,  0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 9'h123, 16'h0000,  2, 16'h0001, 1'b0, 16'h0001, 1'b0};

    sys_rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    drp_do = 16'h0; drp_rdy = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    tick();

    // Stray drp_rdy in IDLE has no effect.
    drp_rdy = 1'b1;
    drp_do  = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_rdy%0d", i), 32'({busy, req0_done, req1_done, drp_en}), 0);
      check($sformatf("idle_rdy%0d_rdata", i), 32'({req0_rdata, req1_rdata}), 0);
    end
    drp_rdy = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during WAIT of a req1 access (last completed access was req0).
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h0AA;
    #1;
    check("rst_ready1", 32'(req1_ready), 1);
    tick();  // ISSUE
    req1_valid = 1'b0;
    tick();  // WAIT
    tick();  // WAIT
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2 sys_rst = 1'b1;
    #1;
    check_all_zero("rst_wait");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drp_rdy = 1'b1;
    drp_do  = 16'hDEAD;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) drp_rdy = 1'b0;
      check($sformatf("post_rst%0d", i), 32'({busy, req0_done, req1_done, drp_en}), 0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("post_rst_grant0", 32'({req0_ready, req1_ready}), 32'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    run_vec(vecs[1], 8);

    // Contention from reset: three accesses each, strict alternation.
    do_reset();
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rem0 = 3; rem1 = 3; ng = 0; en_cnt = 0; d0 = 0; d1 = 0;
    last_acc = -100; min_gap = 1000; en_prev = 0;
    req0_we = 1'b0; req0_addr = 9'h010;
    req1_we = 1'b0; req1_addr = 9'h011;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (drp_en) en_cnt++;
      if (req0_done) d0++;
      if (req1_done) d1++;
      drp_rdy = en_prev;
      en_prev = drp_en;
      req0_valid = (rem0 > 0);
      req1_valid = (rem1 > 0);
      #1;
      if (req0_ready && req1_ready) check("cont_both_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        if (ng < 6) check($sformatf("cont_grant%0d", ng), 32'(g), 32'(exp_order[ng]));
        ng++;
        gap = cyc - last_acc;
        if (ng > 1 && gap < min_gap) min_gap = gap;
        last_acc = cyc;
        if (g) rem1--; else rem0--;
      end
      if (rem0 == 0 && rem1 == 0 && d0 == 3 && d1 == 3) break;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drp_rdy    = 1'b0;
    check("cont_grants",  32'(ng),     6);
    check("cont_drp_en",  32'(en_cnt), 6);
    check("cont_gap_ge4", 32'(min_gap >= 4), 1);
    check("cont_done0",   32'(d0),     3);
    check("cont_done1",   32'(d1),     3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
